// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register-select types, memory-stage FSM
// states and the writeback mux encodings carried through MEM/WB.
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    localparam int REGSEL_W = 5;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [REGSEL_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } memstate_t;

    // Writeback source select driven on memToReg.
    localparam logic [1:0] MEMTOREG_ALU = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM = 2'd1;
    localparam logic [1:0] MEMTOREG_LUI = 2'd2;
    localparam logic [1:0] MEMTOREG_PC4 = 2'd3;

endpackage

// File: rtl/mem_link_reg.sv
// LL/SC link register: armed by a completed LL, disarmed by any completed
// store to the linked word or by an external coherence invalidate.
module mem_link_reg #(
    parameter int ADDR_W = 30
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              store_en,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic              link_clear,
    input  logic [ADDR_W-1:0] check_addr,
    output logic              link_valid,
    output logic              sc_match
);

    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_addr_q,  link_addr_d;

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (set_en) begin
            link_valid_d = 1'b1;
            link_addr_d  = set_addr;
        end
        if (store_en && link_valid_q && (store_addr == link_addr_q)) begin
            link_valid_d = 1'b0;
        end
        // Invalidate is applied last so it beats a simultaneous LL completion.
        if (link_clear) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign link_valid = link_valid_q;
    assign sc_match   = link_valid_q && (check_addr == link_addr_q);

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: issues one data-cache access at a time, waits for dhit,
// and writes a registered single-cycle-valid payload into the MEM/WB latch.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WSEL_W = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              exmem_valid,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              llOp,
    input  logic              scOp,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] storeData,
    input  logic              regWr_in,
    input  logic [WSEL_W-1:0] wsel_in,
    input  logic [1:0]        memToReg_in,
    input  logic              halt_in,
    input  logic [DATA_W-1:0] luiValue_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic              link_clear,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [DATA_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              memwb_valid,
    output logic [DATA_W-1:0] dmemload_out,
    output logic [DATA_W-1:0] portO_out,
    output logic [DATA_W-1:0] luiValue_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic              regWr_out,
    output logic [WSEL_W-1:0] wsel_out,
    output logic [1:0]        memToReg_out,
    output logic              halt_out
);

    localparam logic [DATA_W-1:0] SC_OK = {{(DATA_W-1){1'b0}}, 1'b1};

    memstate_t state_q, state_d;

    // Outstanding request plus the control it must carry to writeback.
    logic              req_read_q,  req_read_d;
    logic              req_write_q, req_write_d;
    logic              req_ll_q,    req_ll_d;
    logic              req_sc_q,    req_sc_d;
    logic [DATA_W-1:0] req_addr_q,  req_addr_d;
    logic [DATA_W-1:0] req_data_q,  req_data_d;
    logic              pend_regwr_q,    pend_regwr_d;
    logic [WSEL_W-1:0] pend_wsel_q,     pend_wsel_d;
    logic [1:0]        pend_memtoreg_q, pend_memtoreg_d;
    logic              pend_halt_q,     pend_halt_d;
    logic [DATA_W-1:0] pend_lui_q,      pend_lui_d;
    logic [DATA_W-1:0] pend_pc4_q,      pend_pc4_d;

    // MEM/WB payload.
    logic              memwb_valid_q,  memwb_valid_d;
    logic [DATA_W-1:0] dmemload_out_q, dmemload_out_d;
    logic [DATA_W-1:0] porto_q,        porto_d;
    logic [DATA_W-1:0] lui_out_q,      lui_out_d;
    logic [DATA_W-1:0] pc4_out_q,      pc4_out_d;
    logic              regwr_out_q,    regwr_out_d;
    logic [WSEL_W-1:0] wsel_out_q,     wsel_out_d;
    logic [1:0]        memtoreg_out_q, memtoreg_out_d;
    logic              halt_out_q,     halt_out_d;

    logic is_mem;
    logic sc_match;
    logic link_valid;
    logic link_set;
    logic store_done;

    assign is_mem = memRead | memWrite | llOp | scOp;

    mem_link_reg #(
        .ADDR_W (DATA_W - 2)
    ) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_en     (link_set),
        .set_addr   (req_addr_q[DATA_W-1:2]),
        .store_en   (store_done),
        .store_addr (req_addr_q[DATA_W-1:2]),
        .link_clear (link_clear),
        .check_addr (aluResult[DATA_W-1:2]),
        .link_valid (link_valid),
        .sc_match   (sc_match)
    );

    always_comb begin
        state_d         = state_q;
        req_read_d      = req_read_q;
        req_write_d     = req_write_q;
        req_ll_d        = req_ll_q;
        req_sc_d        = req_sc_q;
        req_addr_d      = req_addr_q;
        req_data_d      = req_data_q;
        pend_regwr_d    = pend_regwr_q;
        pend_wsel_d     = pend_wsel_q;
        pend_memtoreg_d = pend_memtoreg_q;
        pend_halt_d     = pend_halt_q;
        pend_lui_d      = pend_lui_q;
        pend_pc4_d      = pend_pc4_q;
        memwb_valid_d   = 1'b0;
        dmemload_out_d  = dmemload_out_q;
        porto_d         = porto_q;
        lui_out_d       = lui_out_q;
        pc4_out_d       = pc4_out_q;
        regwr_out_d     = regwr_out_q;
        wsel_out_d      = wsel_out_q;
        memtoreg_out_d  = memtoreg_out_q;
        halt_out_d      = halt_out_q;
        link_set        = 1'b0;
        store_done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (exmem_valid) begin
                    if (is_mem && !(scOp && !sc_match)) begin
                        req_read_d      = memRead | llOp;
                        req_write_d     = memWrite | scOp;
                        req_ll_d        = llOp;
                        req_sc_d        = scOp;
                        req_addr_d      = aluResult;
                        req_data_d      = storeData;
                        pend_regwr_d    = regWr_in;
                        pend_wsel_d     = wsel_in;
                        pend_memtoreg_d = memToReg_in;
                        pend_halt_d     = halt_in;
                        pend_lui_d      = luiValue_in;
                        pend_pc4_d      = pc4_in;
                        state_d         = ACCESS;
                    end else begin
                        // Non-memory op or a failed SC retires straight away.
                        memwb_valid_d  = 1'b1;
                        dmemload_out_d = '0;
                        porto_d        = scOp ? '0 : aluResult;
                        lui_out_d      = luiValue_in;
                        pc4_out_d      = pc4_in;
                        regwr_out_d    = regWr_in;
                        wsel_out_d     = wsel_in;
                        memtoreg_out_d = memToReg_in;
                        halt_out_d     = halt_out_q | halt_in;
                        if (halt_in) begin
                            state_d = HALTED;
                        end
                    end
                end
            end
            ACCESS: begin
                if (dhit) begin
                    memwb_valid_d  = 1'b1;
                    dmemload_out_d = dmemload;
                    porto_d        = req_sc_q ? SC_OK : req_addr_q;
                    lui_out_d      = pend_lui_q;
                    pc4_out_d      = pend_pc4_q;
                    regwr_out_d    = pend_regwr_q;
                    wsel_out_d     = pend_wsel_q;
                    memtoreg_out_d = pend_memtoreg_q;
                    halt_out_d     = halt_out_q | pend_halt_q;
                    link_set       = req_ll_q;
                    store_done     = req_write_q;
                    state_d        = pend_halt_q ? HALTED : IDLE;
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q         <= IDLE;
            req_read_q      <= 1'b0;
            req_write_q     <= 1'b0;
            req_ll_q        <= 1'b0;
            req_sc_q        <= 1'b0;
            req_addr_q      <= '0;
            req_data_q      <= '0;
            pend_regwr_q    <= 1'b0;
            pend_wsel_q     <= '0;
            pend_memtoreg_q <= '0;
            pend_halt_q     <= 1'b0;
            pend_lui_q      <= '0;
            pend_pc4_q      <= '0;
            memwb_valid_q   <= 1'b0;
            dmemload_out_q  <= '0;
            porto_q         <= '0;
            lui_out_q       <= '0;
            pc4_out_q       <= '0;
            regwr_out_q     <= 1'b0;
            wsel_out_q      <= '0;
            memtoreg_out_q  <= '0;
            halt_out_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_read_q      <= req_read_d;
            req_write_q     <= req_write_d;
            req_ll_q        <= req_ll_d;
            req_sc_q        <= req_sc_d;
            req_addr_q      <= req_addr_d;
            req_data_q      <= req_data_d;
            pend_regwr_q    <= pend_regwr_d;
            pend_wsel_q     <= pend_wsel_d;
            pend_memtoreg_q <= pend_memtoreg_d;
            pend_halt_q     <= pend_halt_d;
            pend_lui_q      <= pend_lui_d;
            pend_pc4_q      <= pend_pc4_d;
            memwb_valid_q   <= memwb_valid_d;
            dmemload_out_q  <= dmemload_out_d;
            porto_q         <= porto_d;
            lui_out_q       <= lui_out_d;
            pc4_out_q       <= pc4_out_d;
            regwr_out_q     <= regwr_out_d;
            wsel_out_q      <= wsel_out_d;
            memtoreg_out_q  <= memtoreg_out_d;
            halt_out_q      <= halt_out_d;
        end
    end

    // Stall releases in the dhit cycle so upstream advances on the same edge
    // that retires the access.
    assign mem_stall = (state_q == ACCESS) && !dhit;
    assign dmemREN   = (state_q == ACCESS) && req_read_q;
    assign dmemWEN   = (state_q == ACCESS) && req_write_q;
    assign dmemaddr  = {req_addr_q[DATA_W-1:2], 2'b00};
    assign dmemstore = req_data_q;

    assign memwb_valid  = memwb_valid_q;
    assign dmemload_out = dmemload_out_q;
    assign portO_out    = porto_q;
    assign luiValue_out = lui_out_q;
    assign pc4_out      = pc4_out_q;
    assign regWr_out    = regwr_out_q;
    assign wsel_out     = wsel_out_q;
    assign memToReg_out = memtoreg_out_q;
    assign halt_out     = halt_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, stalled loads,
// LL/SC link behaviour, halt stickiness and reset abandoning an access.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        exmem_valid, memRead, memWrite, llOp, scOp;
    logic [31:0] aluResult, storeData, luiValue_in, pc4_in, dmemload;
    logic        regWr_in, halt_in, link_clear, dhit;
    logic [4:0]  wsel_in;
    logic [1:0]  memToReg_in;
    logic        dmemREN, dmemWEN, mem_stall, memwb_valid, regWr_out, halt_out;
    logic [31:0] dmemaddr, dmemstore, dmemload_out, portO_out, luiValue_out, pc4_out;
    logic [4:0]  wsel_out;
    logic [1:0]  memToReg_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    mem_stage #(.DATA_W(32), .WSEL_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .exmem_valid(exmem_valid), .memRead(memRead),
        .memWrite(memWrite), .llOp(llOp), .scOp(scOp), .aluResult(aluResult),
        .storeData(storeData), .regWr_in(regWr_in), .wsel_in(wsel_in),
        .memToReg_in(memToReg_in), .halt_in(halt_in), .luiValue_in(luiValue_in),
        .pc4_in(pc4_in), .link_clear(link_clear), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .memwb_valid(memwb_valid),
        .dmemload_out(dmemload_out), .portO_out(portO_out),
        .luiValue_out(luiValue_out), .pc4_out(pc4_out), .regWr_out(regWr_out),
        .wsel_out(wsel_out), .memToReg_out(memToReg_out), .halt_out(halt_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        exmem_valid = 0; memRead = 0; memWrite = 0; llOp = 0; scOp = 0;
        aluResult = 0; storeData = 0; regWr_in = 0; wsel_in = 0;
        memToReg_in = MEMTOREG_ALU; halt_in = 0; luiValue_in = 0; pc4_in = 0;
        link_clear = 0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic ll, input logic sc,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wsel, input logic [1:0] m2r);
        clear_inputs();
        exmem_valid = 1; memRead = rd; memWrite = wr; llOp = ll; scOp = sc;
        aluResult = addr; storeData = sdata; regWr_in = 1; wsel_in = wsel;
        memToReg_in = m2r;
    endtask

    initial begin
        clear_inputs();
        dhit = 0; dmemload = 0; nRST = 0;
        // Reset while a load is being presented.
        exmem_valid = 1; memRead = 1; aluResult = 32'h100;
        step(); step();
        chk1("rst_ren", dmemREN, 1'b0);
        chk1("rst_stall", mem_stall, 1'b0);
        chk1("rst_valid", memwb_valid, 1'b0);
        chk("rst_porto", portO_out, 32'h0);
        chk("rst_dload", dmemload_out, 32'h0);
        chk1("rst_halt", halt_out, 1'b0);
        chk("rst_wsel", {27'b0, wsel_out}, 32'h0);
        nRST = 1; clear_inputs();
        step();
        chk1("idle_valid", memwb_valid, 1'b0);

        // ADD: one-cycle pass-through, no stall.
        issue(0, 0, 0, 0, 32'h2A, 0, 5'd5, MEMTOREG_ALU);
        #1 chk1("add_stall", mem_stall, 1'b0);
        step(); clear_inputs();
        chk1("add_valid", memwb_valid, 1'b1);
        chk("add_porto", portO_out, 32'h2A);
        chk("add_wsel", {27'b0, wsel_out}, 32'd5);
        chk1("add_regwr", regWr_out, 1'b1);
        step();
        chk1("add_pulse", memwb_valid, 1'b0);

        // LW 0x104: three stalled cycles, dhit on the fourth access cycle.
        issue(1, 0, 0, 0, 32'h104, 0, 5'd8, MEMTOREG_MEM);
        step();
        issue(0, 0, 0, 0, 32'h999, 0, 5'd3, MEMTOREG_ALU); // ignored while in ACCESS
        for (int i = 0; i < 3; i++) begin
            chk1("lw_ren", dmemREN, 1'b1);
            chk("lw_addr", dmemaddr, 32'h104);
            chk1("lw_stall", mem_stall, 1'b1);
            chk1("lw_valid_wait", memwb_valid, 1'b0);
            step();
        end
        dhit = 1; dmemload = 32'hDEADBEEF;
        #1 chk1("lw_stall_drop", mem_stall, 1'b0);
        step(); dhit = 0; clear_inputs();
        chk1("lw_valid", memwb_valid, 1'b1);
        chk("lw_data", dmemload_out, 32'hDEADBEEF);
        chk("lw_porto", portO_out, 32'h104);
        chk("lw_wsel", {27'b0, wsel_out}, 32'd8);
        chk("lw_m2r", {30'b0, memToReg_out}, {30'b0, MEMTOREG_MEM});
        chk1("lw_ren_off", dmemREN, 1'b0);
        step();
        chk1("lw_pulse", memwb_valid, 1'b0);

        // LL 0x200 then SC 0x200 (succeeds), then SC 0x200 again (fails).
        issue(1, 0, 1, 0, 32'h200, 0, 5'd9, MEMTOREG_MEM);
        step(); clear_inputs();
        dhit = 1; dmemload = 32'h55;
        #1 chk("ll_addr", dmemaddr, 32'h200);
        step(); dhit = 0;
        chk1("ll_valid", memwb_valid, 1'b1);
        chk("ll_data", dmemload_out, 32'h55);
        issue(0, 1, 0, 1, 32'h200, 32'd7, 5'd10, MEMTOREG_ALU);
        step(); clear_inputs();
        chk1("sc1_wen", dmemWEN, 1'b1);
        chk1("sc1_ren", dmemREN, 1'b0);
        chk("sc1_store", dmemstore, 32'd7);
        chk1("sc1_stall", mem_stall, 1'b1);
        dhit = 1;
        step(); dhit = 0;
        chk1("sc1_valid", memwb_valid, 1'b1);
        chk("sc1_porto", portO_out, 32'd1);
        issue(0, 1, 0, 1, 32'h200, 32'd8, 5'd10, MEMTOREG_ALU);
        #1 chk1("sc2_stall", mem_stall, 1'b0);
        step(); clear_inputs();
        chk1("sc2_valid", memwb_valid, 1'b1);
        chk("sc2_porto", portO_out, 32'd0);
        chk1("sc2_wen", dmemWEN, 1'b0);

        // LL 0x300 with link_clear on its dhit cycle: SC must fail.
        issue(1, 0, 1, 0, 32'h300, 0, 5'd11, MEMTOREG_MEM);
        step(); clear_inputs();
        dhit = 1; link_clear = 1;
        step(); dhit = 0; link_clear = 0;
        chk1("llc_valid", memwb_valid, 1'b1);
        issue(0, 1, 0, 1, 32'h300, 32'd9, 5'd12, MEMTOREG_ALU);
        step(); clear_inputs();
        chk("llc_sc_porto", portO_out, 32'd0);
        chk1("llc_sc_wen", dmemWEN, 1'b0);
        chk1("llc_sc_stall", mem_stall, 1'b0);

        // LL 0x400 with immediate dhit (2-cycle), SW to 0x400 clears link, SC fails.
        issue(1, 0, 1, 0, 32'h400, 0, 5'd13, MEMTOREG_MEM);
        step(); clear_inputs(); dhit = 1;
        step(); dhit = 0;
        chk1("ll4_valid_2cyc", memwb_valid, 1'b1);
        issue(0, 1, 0, 0, 32'h400, 32'h11, 5'd0, MEMTOREG_ALU);
        regWr_in = 0;
        step(); clear_inputs(); dhit = 1;
        step(); dhit = 0;
        chk1("sw4_valid", memwb_valid, 1'b1);
        issue(0, 1, 0, 1, 32'h400, 32'h22, 5'd14, MEMTOREG_ALU);
        step(); clear_inputs();
        chk("sc4_porto", portO_out, 32'd0);
        chk1("sc4_wen", dmemWEN, 1'b0);

        // Halt retires, then further ops are ignored until reset.
        clear_inputs(); exmem_valid = 1; halt_in = 1;
        step(); clear_inputs();
        chk1("halt_valid", memwb_valid, 1'b1);
        chk1("halt_out", halt_out, 1'b1);
        issue(0, 0, 0, 0, 32'h77, 0, 5'd6, MEMTOREG_ALU);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("halted_valid", memwb_valid, 1'b0);
            chk1("halted_sticky", halt_out, 1'b1);
            chk1("halted_stall", mem_stall, 1'b0);
        end
        issue(1, 0, 0, 0, 32'h500, 0, 5'd7, MEMTOREG_MEM);
        step();
        chk1("halted_ren", dmemREN, 1'b0);
        chk1("halted_wen", dmemWEN, 1'b0);
        nRST = 0;
        step();
        chk1("halt_rst", halt_out, 1'b0);
        issue(0, 0, 0, 0, 32'h77, 0, 5'd6, MEMTOREG_ALU);
        nRST = 1;
        step(); clear_inputs();
        chk1("post_halt_valid", memwb_valid, 1'b1);
        chk("post_halt_porto", portO_out, 32'h77);

        // Reset in ACCESS abandons the load; a late dhit is ignored.
        issue(1, 0, 0, 0, 32'h600, 0, 5'd15, MEMTOREG_MEM);
        step(); clear_inputs();
        chk1("abandon_ren_pre", dmemREN, 1'b1);
        nRST = 0;
        step();
        chk1("abandon_ren", dmemREN, 1'b0);
        nRST = 1; dhit = 1; dmemload = 32'hBAD0BAD0;
        step(); dhit = 0;
        chk1("abandon_valid", memwb_valid, 1'b0);
        chk("abandon_dload", dmemload_out, 32'h0);
        chk1("abandon_ren_after", dmemREN, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
